// File: rtl/gb_cpu_common_pkg.sv
// Shared definitions for the GB CPU front end: fetch FSM encoding, fixed
// opcode constants and the hard-lock opcode classifier.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    FETCH_CB = 2'd1,
    HOLD     = 2'd2,
    LOCKED   = 2'd3
  } fetch_state_t;

  localparam logic [7:0]  CB_PREFIX_OPCODE = 8'hCB;
  localparam logic [15:0] RESET_PC         = 16'h0000;

  // Unassigned opcodes that hang the real CPU until reset.
  function automatic logic is_hard_lock(input logic [7:0] op);
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: is_hard_lock = 1'b1;
      default:                           is_hard_lock = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gb_cpu_fetch_buf.sv
// One-byte prefetch buffer used while the decoder holds an instruction.
module gb_cpu_fetch_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       write,
  input  logic [7:0] wdata,
  input  logic       consume,
  output logic       full,
  output logic [7:0] data
);

  // Buffer occupancy and contents; clear and consume win over write.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= 8'h00;
    end else if (clear || consume) begin
      full <= 1'b0;
    end else if (write) begin
      full <= 1'b1;
      data <= wdata;
    end
  end

endmodule

// File: rtl/gb_cpu_fetch.sv
// GB CPU instruction fetch: byte reads, 0xCB prefix merging, hard-lock
// detection and a valid/ready instruction register toward the decoder.
// Optional feature macro: GB_FETCH_PREFETCH_EN (one-byte prefetch buffer).
//
// Handshakes: the memory read completes on any cycle where mem_req and
// mem_ack are both 1; the decoder takes the IR on any cycle where ir_valid
// and ir_ready are both 1, and the IR fields stay frozen until then.
module gb_cpu_fetch
  import gb_cpu_common_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic [15:0] ir_pc,
  output logic [15:0] pc,
  output logic        locked
);

  fetch_state_t state;
  logic         ack_ok;
  logic         buf_full;
  logic [7:0]   buf_data;
  logic         proc_valid;
  logic [7:0]   proc_byte;
  logic [15:0]  proc_addr;

`ifdef GB_FETCH_PREFETCH_EN
  assign mem_req = (state == FETCH) || (state == FETCH_CB) ||
                   ((state == HOLD) && !buf_full);

  gb_cpu_fetch_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (redirect_valid && (state != LOCKED)),
    .write   ((state == HOLD) && !ir_ready && ack_ok && !redirect_valid),
    .wdata   (mem_rdata),
    .consume ((state == HOLD) && ir_ready),
    .full    (buf_full),
    .data    (buf_data)
  );
`else
  assign mem_req  = (state == FETCH) || (state == FETCH_CB);
  assign buf_full = 1'b0;
  assign buf_data = 8'h00;
`endif

  assign mem_addr = pc;
  assign ack_ok   = mem_req && mem_ack;
  assign ir_valid = (state == HOLD);
  assign locked   = (state == LOCKED);

  // Select the first-byte candidate: a fresh ack in FETCH, or on a HOLD
  // handshake the buffered byte (fetched at pc-1) or a same-cycle ack.
  always_comb begin
    proc_valid = 1'b0;
    proc_byte  = mem_rdata;
    proc_addr  = pc;
    if (state == FETCH) begin
      proc_valid = ack_ok;
    end else if ((state == HOLD) && ir_ready) begin
      if (buf_full) begin
        proc_valid = 1'b1;
        proc_byte  = buf_data;
        proc_addr  = pc - 16'd1;
      end else begin
        proc_valid = ack_ok;
      end
    end
  end

  // Fetch FSM, program counter and IR fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      opcode    <= 8'h00;
      cb_prefix <= 1'b0;
      ir_pc     <= RESET_PC;
    end else if (state != LOCKED) begin
      if (redirect_valid) begin
        pc    <= redirect_pc;
        state <= FETCH;
      end else begin
        if (ack_ok) pc <= pc + 16'd1;
        case (state)
          FETCH_CB: begin
            if (ack_ok) begin
              opcode    <= mem_rdata;
              cb_prefix <= 1'b1;
              state     <= HOLD;
            end
          end
          HOLD: begin
            if (ir_ready && !proc_valid) state <= FETCH;
          end
          default: ;
        endcase
        if (proc_valid) begin
          if (proc_byte == CB_PREFIX_OPCODE) begin
            ir_pc <= proc_addr;
            state <= FETCH_CB;
          end else if (is_hard_lock(proc_byte)) begin
            state <= LOCKED;
          end else begin
            opcode    <= proc_byte;
            cb_prefix <= 1'b0;
            ir_pc     <= proc_addr;
            state     <= HOLD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gb_cpu_fetch.sv
// Directed bench for gb_cpu_fetch with hand-computed expectations.
module tb_gb_cpu_fetch;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic [15:0] ir_pc;
  logic [15:0] pc;
  logic        locked;

  int n_tests;
  int n_fail;

  gb_cpu_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .opcode         (opcode),
    .cb_prefix      (cb_prefix),
    .ir_pc          (ir_pc),
    .pc             (pc),
    .locked         (locked)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers: called at a negedge, return at the negedge after the edge
  // that consumed the stimulus.
  task automatic ack_byte(input logic [7:0] d);
    int waited;
    waited = 0;
    while (!mem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("mem_req_wait", {31'd0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = d;
    @(negedge clk);
    mem_ack   = 1'b0;
  endtask

  task automatic handshake();
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;
    mem_ack = 1'b0; mem_rdata = 8'h0; ir_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check_eq("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("rst_pc", {16'd0, pc}, 32'h0000);
    check_eq("rst_opcode", {24'd0, opcode}, 32'h00);
    check_eq("rst_cb", {31'd0, cb_prefix}, 32'd0);
    check_eq("rst_ir_pc", {16'd0, ir_pc}, 32'h0000);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    reset = 1'b0;
    check_eq("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("post_rst_mem_addr", {16'd0, mem_addr}, 32'h0000);

    // Plain opcode, one-cycle latency
    ack_byte(8'h3E);
    check_eq("ld_ir_valid", {31'd0, ir_valid}, 32'd1);
    check_eq("ld_opcode", {24'd0, opcode}, 32'h3E);
    check_eq("ld_cb", {31'd0, cb_prefix}, 32'd0);
    check_eq("ld_ir_pc", {16'd0, ir_pc}, 32'h0000);
    check_eq("ld_pc", {16'd0, pc}, 32'h0001);
`ifndef GB_FETCH_PREFETCH_EN
    check_eq("hold_mem_req", {31'd0, mem_req}, 32'd0);
`endif
    handshake();
    check_eq("hs_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("hs_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("hs_mem_addr", {16'd0, mem_addr}, 32'h0001);

    // CB-prefixed instruction at 0x0010, held by decoder
    redirect(16'h0010);
    check_eq("redir_mem_addr", {16'd0, mem_addr}, 32'h0010);
    ack_byte(8'hCB);
    check_eq("cb1_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("cb1_mem_addr", {16'd0, mem_addr}, 32'h0011);
    ack_byte(8'h37);
    for (int i = 0; i < 6; i++) begin
      check_eq("cb_ir_valid", {31'd0, ir_valid}, 32'd1);
      check_eq("cb_opcode", {24'd0, opcode}, 32'h37);
      check_eq("cb_flag", {31'd0, cb_prefix}, 32'd1);
      check_eq("cb_ir_pc", {16'd0, ir_pc}, 32'h0010);
      check_eq("cb_pc", {16'd0, pc}, 32'h0012);
      if (i < 5) @(negedge clk);
    end
    handshake();

    // Redirect while holding an instruction
    ack_byte(8'h00);
    redirect(16'h0030);
    check_eq("hold_redir_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("hold_redir_pc", {16'd0, pc}, 32'h0030);

    // PC wrap, then redirect coinciding with an ack
    redirect(16'hFFFF);
    ack_byte(8'h00);
    check_eq("wrap_pc", {16'd0, pc}, 32'h0000);
    check_eq("wrap_ir_pc", {16'd0, ir_pc}, 32'hFFFF);
    handshake();
    mem_ack = 1'b1; mem_rdata = 8'h3E;
    redirect(16'h0038);
    mem_ack = 1'b0;
    check_eq("ack_redir_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("ack_redir_mem_addr", {16'd0, mem_addr}, 32'h0038);
    check_eq("ack_redir_mem_req", {31'd0, mem_req}, 32'd1);

    // Redirect between 0xCB and its second byte drops the prefix
    ack_byte(8'hCB);
    redirect(16'h0040);
    ack_byte(8'h05);
    check_eq("cbdrop_cb", {31'd0, cb_prefix}, 32'd0);
    check_eq("cbdrop_opcode", {24'd0, opcode}, 32'h05);
    check_eq("cbdrop_ir_pc", {16'd0, ir_pc}, 32'h0040);
    handshake();

    // Hard-lock byte after 0xCB is an ordinary CB opcode
    ack_byte(8'hCB);
    ack_byte(8'hD3);
    check_eq("cbd3_locked", {31'd0, locked}, 32'd0);
    check_eq("cbd3_opcode", {24'd0, opcode}, 32'hD3);
    check_eq("cbd3_ir_pc", {16'd0, ir_pc}, 32'h0041);
    handshake();

    // Hard lock: ignores redirect, ack and ready
    ack_byte(8'hD3);
    check_eq("lock_locked", {31'd0, locked}, 32'd1);
    check_eq("lock_ir_valid", {31'd0, ir_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0100; mem_ack = 1'b1; ir_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0;
    check_eq("lock_hold", {31'd0, locked}, 32'd1);
    check_eq("lock_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("lock_pc", {16'd0, pc}, 32'h0044);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("unlock_locked", {31'd0, locked}, 32'd0);
    check_eq("unlock_mem_req", {31'd0, mem_req}, 32'd1);

    // Reset mid-HOLD wins over a redirect
    ack_byte(8'h3C);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200;
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0;
    check_eq("rst_hold_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("rst_hold_pc", {16'd0, pc}, 32'h0000);

`ifdef GB_FETCH_PREFETCH_EN
    // Back-to-back NOPs with single-cycle acks
    mem_ack = 1'b1; mem_rdata = 8'h00; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("pf_ir_valid", {31'd0, ir_valid}, 32'd1);
      check_eq("pf_ir_pc", {16'd0, ir_pc}, i);
    end
    ir_ready = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("pf_full_mem_req", {31'd0, mem_req}, 32'd0);
    redirect(16'h0080);
    check_eq("pf_redir_mem_addr", {16'd0, mem_addr}, 32'h0080);
    ack_byte(8'h3E);
    check_eq("pf_empty_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("pf_opcode", {24'd0, opcode}, 32'h3E);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
